// File: rtl/flappy_pkg.sv
// flappy_pkg: column geometry, opening limits and game state encodings shared by the
//   column generator and the collision detector.
package flappy_pkg;
  localparam int COL1_X = 32;
  localparam int COL2_X = 64;
  localparam int COL3_X = 96;
  localparam int COL4_X = 128;
  localparam int UP_WIDTH = 11;
  localparam int DOWN_WIDTH = 34;
  localparam int GROUND_Y = 121;
  localparam logic [6:0] OP_MIN = 7'd16;
  localparam logic [6:0] OP_INIT = 7'd48;
  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_e;
endpackage

// File: rtl/column_generator_if.sv
// column_generator_if: game-control inputs and column/score outputs of the column generator.
//   master: drives frame_tick/start/collided, observes col1..4_op, score, running, game_over, shift_pulse
//   slave : the column generator side
interface column_generator_if;
  logic frame_tick;
  logic start;
  logic collided;
  logic [6:0] col1_op;
  logic [6:0] col2_op;
  logic [6:0] col3_op;
  logic [6:0] col4_op;
  logic [7:0] score;
  logic running;
  logic game_over;
  logic shift_pulse;
  modport master (
    output frame_tick, start, collided,
    input col1_op, col2_op, col3_op, col4_op, score, running, game_over, shift_pulse
  );
  modport slave (
    input frame_tick, start, collided,
    output col1_op, col2_op, col3_op, col4_op, score, running, game_over, shift_pulse
  );
endinterface

// File: rtl/opening_lfsr.sv
// opening_lfsr: free-running 7-bit Fibonacci LFSR (x^7+x^6+1), steps every clock.
//   clk, reset (sync, active-high, loads SEED) -> q_o[6:0] current LFSR state
module opening_lfsr #(
  parameter logic [6:0] SEED = 7'h5A
) (
  input  logic       clk,
  input  logic       reset,
  output logic [6:0] q_o
);
  logic [6:0] q_q;
  always_ff @(posedge clk)
    q_q <= reset ? SEED : {q_q[5:0], q_q[6] ^ q_q[5]};
  assign q_o = q_q;
endmodule

// File: rtl/column_generator.sv
// column_generator: scrolls four column openings, draws new ones from an LFSR, keeps score
//   and the IDLE/RUN/DEAD game state.
//   clk, reset (sync, active-high); bus (column_generator_if.slave): frame_tick/start/collided in,
//   col1..4_op, score, running, game_over, shift_pulse out.
//   DIFFICULTY_RAMP_EN: when defined, the shift period shrinks by one frame every 8th shift down to 10.
module column_generator #(
  parameter int SHIFT_FRAMES = 30,
  parameter logic [6:0] OP_INIT = flappy_pkg::OP_INIT,
  parameter logic [6:0] OP_MIN = flappy_pkg::OP_MIN,
  parameter logic [6:0] LFSR_SEED = 7'h5A
) (
  input logic clk,
  input logic reset,
  column_generator_if.slave bus
);
  import flappy_pkg::*;
  state_e state_q, state_d;
  logic [6:0] lfsr;
  logic [6:0] op_q [4];
  logic [7:0] cnt_q, score_q, period;
  logic pulse_q, enter_run, advance, shift;
  logic unused_lfsr_msb;
  opening_lfsr #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .reset(reset), .q_o(lfsr));
  assign unused_lfsr_msb = lfsr[6];
  assign enter_run = state_q != RUN && bus.start;
  // collision wins over a shift landing on the same tick
  assign advance = state_q == RUN && bus.frame_tick && !bus.collided;
  assign shift = advance && cnt_q == period - 8'd1;
`ifdef DIFFICULTY_RAMP_EN
  logic [7:0] period_q;
  logic [2:0] nshift_q;
  always_ff @(posedge clk)
    if (reset || enter_run) begin
      period_q <= 8'(SHIFT_FRAMES);
      nshift_q <= '0;
    end else if (shift) begin
      nshift_q <= nshift_q + 3'd1;
      if (nshift_q == 3'd7) period_q <= period_q > 8'd10 ? period_q - 8'd1 : period_q;
    end
  assign period = period_q;
`else
  assign period = 8'(SHIFT_FRAMES);
`endif
  always_ff @(posedge clk)
    state_q <= reset ? IDLE : state_d;
  always_comb
    state_d = state_q == RUN ? (bus.collided ? DEAD : RUN) : (bus.start ? RUN : state_q);
  always_comb begin
    bus.running = state_q == RUN;
    bus.game_over = state_q == DEAD;
  end
  always_ff @(posedge clk)
    if (reset || enter_run) begin
      for (int i = 0; i < 4; i++) op_q[i] <= OP_INIT;
      score_q <= '0;
      cnt_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= shift;
      if (advance) cnt_q <= shift ? 8'd0 : cnt_q + 8'd1;
      if (shift) begin
        op_q[0] <= op_q[1];
        op_q[1] <= op_q[2];
        op_q[2] <= op_q[3];
        op_q[3] <= {1'b0, lfsr[5:0]} + OP_MIN;
        score_q <= score_q == 8'hFF ? score_q : score_q + 8'd1;
      end
    end
  assign bus.col1_op = op_q[0];
  assign bus.col2_op = op_q[1];
  assign bus.col3_op = op_q[2];
  assign bus.col4_op = op_q[3];
  assign bus.score = score_q;
  assign bus.shift_pulse = pulse_q;
endmodule

// File: tb/tb_column_generator.sv
// tb_column_generator: directed scoreboard bench for column_generator against a cycle model.
module tb_column_generator;
  typedef struct packed {
    logic [6:0] c1, c2, c3, c4;
    logic [7:0] score;
    logic run, over, pulse;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  int draws = 0;
  exp_t sb[$];
  int m_state = 0;
  logic [6:0] m_op [4] = '{7'd48, 7'd48, 7'd48, 7'd48};
  logic [7:0] m_score = 8'd0, m_cnt = 8'd0, m_period = 8'd30;
  int m_shifts = 0;
  logic [6:0] m_lfsr = 7'h5A;
  logic m_pulse = 1'b0;
  column_generator_if bus();
  column_generator dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic model(input logic r, input logic ft, input logic st, input logic co);
    logic [6:0] draw;
    if (r) begin
      m_state = 0;
      for (int i = 0; i < 4; i++) m_op[i] = 7'd48;
      m_score = 0; m_cnt = 0; m_period = 8'd30; m_shifts = 0; m_pulse = 0;
      m_lfsr = 7'h5A;
      return;
    end
    draw = {1'b0, m_lfsr[5:0]} + 7'd16;
    m_pulse = 0;
    if (m_state != 1) begin
      if (st) begin
        m_state = 1;
        for (int i = 0; i < 4; i++) m_op[i] = 7'd48;
        m_score = 0; m_cnt = 0; m_period = 8'd30; m_shifts = 0;
      end
    end else if (co) m_state = 2;
    else if (ft) begin
      if (m_cnt == m_period - 8'd1) begin
        m_cnt = 0;
        m_op[0] = m_op[1]; m_op[1] = m_op[2]; m_op[2] = m_op[3]; m_op[3] = draw;
        if (m_score != 8'd255) m_score = m_score + 8'd1;
        m_pulse = 1;
        m_shifts++;
`ifdef DIFFICULTY_RAMP_EN
        if (m_shifts % 8 == 0 && m_period > 8'd10) m_period = m_period - 8'd1;
`endif
      end else m_cnt = m_cnt + 8'd1;
    end
    m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
  endtask
  task automatic step(input logic r, input logic ft, input logic st, input logic co);
    exp_t e;
    @(negedge clk);
    reset = r; bus.frame_tick = ft; bus.start = st; bus.collided = co;
    model(r, ft, st, co);
    sb.push_back('{m_op[0], m_op[1], m_op[2], m_op[3], m_score, m_state == 1, m_state == 2, m_pulse});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("col1", bus.col1_op, e.c1);
    check("col2", bus.col2_op, e.c2);
    check("col3", bus.col3_op, e.c3);
    check("col4", bus.col4_op, e.c4);
    check("score", bus.score, e.score);
    check("running", bus.running, e.run);
    check("game_over", bus.game_over, e.over);
    check("shift_pulse", bus.shift_pulse, e.pulse);
    if (bus.shift_pulse === 1'b1) begin
      draws++;
      check("col4_range", bus.col4_op >= 7'd16 && bus.col4_op <= 7'd79, 1);
    end
  endtask
  initial begin
    bus.frame_tick = 0; bus.start = 0; bus.collided = 0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("t1_col1", bus.col1_op, 48);
    check("t1_col4", bus.col4_op, 48);
    check("t1_score", bus.score, 0);
    check("t1_running", bus.running, 0);
    check("t1_over", bus.game_over, 0);
    check("t1_pulse", bus.shift_pulse, 0);
    step(0, 0, 1, 0);
    repeat (30) step(0, 1, 0, 0);
    check("t2_pulse", bus.shift_pulse, 1);
    check("t2_col3", bus.col3_op, 48);
    check("t2_col4_range", bus.col4_op >= 7'd16 && bus.col4_op <= 7'd79, 1);
    check("t2_score", bus.score, 1);
    step(0, 0, 1, 0);
    check("t2_pulse_off", bus.shift_pulse, 0);
    check("t2_start_ignored", bus.score, 1);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    repeat (29) step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    check("t3_over", bus.game_over, 1);
    check("t3_pulse", bus.shift_pulse, 0);
    check("t3_score", bus.score, 0);
    check("t3_col4", bus.col4_op, 48);
    repeat (100) step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    check("t4_frozen", bus.game_over, 1);
    step(0, 0, 1, 0);
    check("t4_running", bus.running, 1);
    check("t4_col2", bus.col2_op, 48);
    check("t4_score", bus.score, 0);
    draws = 0;
    repeat (7700) step(0, 1, 0, 0);
    check("t5_score_sat", bus.score, 255);
    check("t5_draws", draws >= 127, 1);
`ifdef DIFFICULTY_RAMP_EN
    check("t5_period_floor", m_period, 10);
`endif
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    repeat (90) step(0, 1, 0, 0);
    check("t6_score", bus.score, 3);
    step(1, 0, 0, 0);
    check("t6_running", bus.running, 0);
    check("t6_col1", bus.col1_op, 48);
    check("t6_col4", bus.col4_op, 48);
    check("t6_score0", bus.score, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
